seg_scan_ctrl: RTL and testbench

//   Display controller for the multi-digit seven-segment panel. Accepts a binary value over a

---
 rtl/seg_scan_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Seven-segment display controller: binary in over valid/ready, serial double-dabble to BCD,
// then time-multiplexed scan of the committed digits onto a shared segment bus.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        bin_in,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf,
    output logic [1:0]              dbg_state
);

    // Handshake: a value is taken on a rising clk edge where in_valid && in_ready are both 1;
    // in_ready is a registered level, so in_valid seen while in_ready=0 is simply ignored.

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BIT_W = $clog2(BIN_W + 1);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam logic [BIN_W-1:0] MAX_VAL   = BIN_W'(pow10(NUM_DIGITS) - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = v[i*4 +: 4];
            if (nib >= 4'd5) begin
                r[i*4 +: 4] = nib + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    state_t            r_state;
    logic              r_ready;
    logic [BCD_W-1:0]  r_work;
    logic [BIN_W-1:0]  r_shift;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_ovf_pend;
    logic [BCD_W-1:0]  r_bcd;
    logic              r_ovf;

    logic [CNT_W-1:0]      r_scan_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_accept;
    logic [BCD_W-1:0]      w_adj;
    logic [3:0]            w_digit;
    logic                  w_digit_blank;
    logic [NUM_DIGITS-1:0] w_an_next;
    logic [NUM_DIGITS-1:0] w_hi_zero;
    logic                  w_zero_run;
    logic [6:0]            w_seg_next;

    assign w_accept = (r_state == S_IDLE) && in_valid && r_ready;
    assign w_adj    = add3(r_work);

    // Overflowed inputs still sit in CONV for BIN_W cycles so latency never depends on the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_work     <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_ovf_pend <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_ready <= (r_state == S_IDLE) && !w_accept;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_CONV;
                        if (bin_in > MAX_VAL) begin
                            r_ovf_pend <= 1'b1;
                            r_work     <= ALL_NINES;
                            r_shift    <= '0;
                        end else begin
                            r_ovf_pend <= 1'b0;
                            r_work     <= '0;
                            r_shift    <= bin_in;
                        end
                    end
                end
                S_CONV: begin
                    if (!r_ovf_pend) begin
                        r_work  <= {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
                        r_shift <= {r_shift[BIN_W-2:0], 1'b0};
                    end
                    if (r_bit_cnt == BIT_W'(BIN_W - 1)) begin
                        r_state <= S_COMMIT;
                    end
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                end
                S_COMMIT: begin
                    r_bcd   <= r_work;
                    r_ovf   <= r_ovf_pend;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Digit select, leading-zero detection and segment decode for the digit under scan.
    always_comb begin
        w_digit       = '0;
        w_digit_blank = 1'b0;
        w_an_next     = '0;
        w_hi_zero     = '0;
        w_zero_run    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run   = w_zero_run && (r_bcd[i*4 +: 4] == 4'd0);
            w_hi_zero[i] = w_zero_run;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit       = r_bcd[i*4 +: 4];
                w_an_next[i]  = 1'b1;
                w_digit_blank = (BLANK_LZ != 0) && (i > 0) && w_hi_zero[i];
            end
        end
        w_seg_next = w_digit_blank ? 7'h00 : seg_decode(w_digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_seg      <= '0;
            r_an       <= '0;
        end else begin
            if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + CNT_W'(1);
            end
            if (blank) begin
                r_seg <= '0;
                r_an  <= '0;
            end else begin
                r_seg <= w_seg_next;
                r_an  <= w_an_next;
            end
        end
    end

    assign in_ready  = r_ready;
    assign seg       = r_seg;
    assign an        = r_an;
    assign bcd       = r_bcd;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, 14-bit input, one scan step per clock).
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int BW = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] bin_in = '0;
    logic          blank = 1'b0;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic [15:0]   bcd;
    logic          ovf;
    logic [1:0]    dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    int ec;

    seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .BIN_W     (BW),
        .SCAN_DIV  (1),
        .BLANK_LZ  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bin_in   (bin_in),
        .blank    (blank),
        .seg      (seg),
        .an       (an),
        .bcd      (bcd),
        .ovf      (ovf),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the scan position after edge k is digit (k-1) mod 4.
    always @(posedge clk) begin
        if (!rst_n) ec <= 0;
        else        ec <= ec + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_scan(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
        logic [6:0] exp_seg [4];
        int         i;
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        exp_seg[3] = s3;
        for (int k = 0; k < 4; k++) begin
            step();
            i = (ec - 1) % 4;
            chk({tag, "_an"}, 32'(an), 32'(1) << i);
            chk({tag, "_seg"}, 32'(seg), 32'(exp_seg[i]));
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
    endtask

    task automatic send(input string tag, input logic [BW-1:0] v, input logic [15:0] prev_b,
                        input logic prev_o, input logic [15:0] exp_b, input logic exp_o);
        wait_ready(tag);
        in_valid = 1'b1;
        bin_in   = v;
        step();
        in_valid = 1'b0;
        chk({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
        repeat (BW) step();
        chk({tag, "_bcd_hold"}, 32'(bcd), 32'(prev_b));
        chk({tag, "_ovf_hold"}, 32'(ovf), 32'(prev_o));
        chk({tag, "_rdy_conv"}, 32'(in_ready), 32'd0);
        step();
        chk({tag, "_bcd"}, 32'(bcd), 32'(exp_b));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
        chk({tag, "_rdy_commit"}, 32'(in_ready), 32'd0);
        step();
        chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_an", 32'(an), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);

        rst_n = 1'b1;
        check_scan("por", 7'h00, 7'h00, 7'h00, 7'h3F);
        chk("por_ready", 32'(in_ready), 32'd1);

        send("v1234", 14'd1234, 16'h0000, 1'b0, 16'h1234, 1'b0);
        check_scan("s1234", 7'h06, 7'h5B, 7'h4F, 7'h66);

        send("v12000", 14'd12000, 16'h1234, 1'b0, 16'h9999, 1'b1);
        check_scan("s9999", 7'h6F, 7'h6F, 7'h6F, 7'h6F);

        send("v7", 14'd7, 16'h9999, 1'b1, 16'h0007, 1'b0);
        check_scan("s7", 7'h00, 7'h00, 7'h00, 7'h07);

        // 55 is held on the bus throughout the conversion of 1234.
        wait_ready("hold");
        in_valid = 1'b1;
        bin_in   = 14'd1234;
        step();
        bin_in = 14'd55;
        repeat (BW + 1) step();
        chk("hold_bcd_1234", 32'(bcd), 32'h1234);
        chk("hold_rdy_commit", 32'(in_ready), 32'd0);
        step();
        chk("hold_rdy_back", 32'(in_ready), 32'd1);
        step();
        chk("hold_rdy_taken", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        repeat (BW) step();
        chk("hold_bcd_still", 32'(bcd), 32'h1234);
        step();
        chk("hold_bcd_55", 32'(bcd), 32'h0055);
        chk("hold_ovf_55", 32'(ovf), 32'd0);
        check_scan("s55", 7'h00, 7'h00, 7'h6D, 7'h6D);

        wait_ready("rstmid");
        in_valid = 1'b1;
        bin_in   = 14'd999;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_seg", 32'(seg), 32'd0);
        chk("rstmid_an", 32'(an), 32'd0);
        chk("rstmid_bcd", 32'(bcd), 32'd0);
        chk("rstmid_ovf", 32'(ovf), 32'd0);
        chk("rstmid_ready", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        check_scan("rstmid_scan", 7'h00, 7'h00, 7'h00, 7'h3F);
        chk("rstmid_ready_back", 32'(in_ready), 32'd1);
        repeat (20) step();
        chk("rstmid_no_commit", 32'(bcd), 32'd0);

        send("vblank", 14'd1234, 16'h0000, 1'b0, 16'h1234, 1'b0);
        blank = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("blank_seg", 32'(seg), 32'd0);
            chk("blank_an", 32'(an), 32'd0);
        end
        blank = 1'b0;
        check_scan("unblank", 7'h06, 7'h5B, 7'h4F, 7'h66);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
